// File: rtl/demux8_saidas_32bits_reg.sv
// rtl/demux8_saidas_32bits_reg.sv - registered 1-to-8 demux with per-slot valid/ready (optional DEMUX_BCAST_EN)
module demux8_saidas_32bits_reg #(
    parameter int LARGURA = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           controlador,
    input  logic [LARGURA-1:0]   entrada,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*LARGURA-1:0] saidas,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    input  logic                 bcast
);

    logic [LARGURA-1:0] dado [8];
    logic [7:0]         val;
    logic [7:0]         livre;
    logic [7:0]         escreve;

    // A slot can take a word when empty or being drained this same cycle.
    assign livre = ~val | out_ready;

`ifdef DEMUX_BCAST_EN
    always_comb begin
        in_ready = bcast ? (&livre) : livre[controlador];
        escreve  = 8'h00;
        if (in_valid && in_ready) begin
            escreve = bcast ? 8'hFF : (8'b1 << controlador);
        end
    end
`else
    logic unused_bcast;
    assign unused_bcast = bcast;

    always_comb begin
        in_ready = livre[controlador];
        escreve  = 8'h00;
        if (in_valid && in_ready) begin
            escreve = 8'b1 << controlador;
        end
    end
`endif

    // A write to a slot overrides a same-cycle consume so the slot stays full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                dado[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (escreve[k]) begin
                    dado[k] <= entrada;
                    val[k]  <= 1'b1;
                end else if (out_ready[k]) begin
                    val[k]  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = val;

    for (genvar g = 0; g < 8; g++) begin : g_saida
        assign saidas[g*LARGURA +: LARGURA] = dado[g];
    end

endmodule

// File: tb/tb_demux8_saidas_32bits_reg.sv
// tb/tb_demux8_saidas_32bits_reg.sv - directed self-checking bench for demux8_saidas_32bits_reg
module tb_demux8_saidas_32bits_reg;

    logic         clk;
    logic         reset_n;
    logic [2:0]   controlador;
    logic [31:0]  entrada;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] saidas;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic         bcast;

    int n_checks = 0;
    int n_pass   = 0;

    demux8_saidas_32bits_reg #(.LARGURA(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .controlador (controlador),
        .entrada     (entrada),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .saidas      (saidas),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bcast       (bcast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] slot(input int k);
        return saidas[k*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        controlador = 3'd0;
        entrada     = 32'h0;
        in_valid    = 1'b0;
        out_ready   = 8'h00;
        bcast       = 1'b0;
        #12;
        chk("rst_out_valid", {24'h0, out_valid}, 32'h0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_slot%0d", k), slot(k), 32'h0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            controlador = 3'(k);
            #1;
            chk($sformatf("idle_in_ready_c%0d", k), {31'h0, in_ready}, 32'h1);
        end

        // Unicast write to slot 3, then a blocked second write
        controlador = 3'd3; entrada = 32'hDEADBEEF; in_valid = 1'b1; #1;
        chk("w3_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        entrada = 32'hCAFEF00D; #1;
        chk("w3_out_valid", {24'h0, out_valid}, 32'h08);
        chk("w3_slot3", slot(3), 32'hDEADBEEF);
        chk("w3_full_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        chk("w3_hold_slot3", slot(3), 32'hDEADBEEF);
        chk("w3_hold_valid", {24'h0, out_valid}, 32'h08);
        in_valid = 1'b0; out_ready = 8'h08;
        step();
        out_ready = 8'h00;
        chk("w3_drain", {24'h0, out_valid}, 32'h00);

        // Full-throughput consume + write on slot 5
        controlador = 3'd5; entrada = 32'h11111111; in_valid = 1'b1;
        step();
        entrada = 32'h12345678; out_ready = 8'h20; #1;
        chk("w5_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0; out_ready = 8'h00;
        chk("w5_out_valid", {24'h0, out_valid}, 32'h20);
        chk("w5_slot5", slot(5), 32'h12345678);
        out_ready = 8'h20;
        step();
        out_ready = 8'h00;
        chk("w5_drain", {24'h0, out_valid}, 32'h00);

        // Back-to-back writes to slots 0 and 7, drained together
        controlador = 3'd0; entrada = 32'h1; in_valid = 1'b1;
        step();
        controlador = 3'd7; entrada = 32'h2;
        step();
        in_valid = 1'b0;
        chk("w07_out_valid", {24'h0, out_valid}, 32'h81);
        chk("w07_slot0", slot(0), 32'h1);
        chk("w07_slot7", slot(7), 32'h2);
        out_ready = 8'h81;
        step();
        out_ready = 8'h00;
        chk("w07_drain", {24'h0, out_valid}, 32'h00);

        // in_valid low with unknown routing must leave state untouched
        controlador = 'x; entrada = 'x;
        step();
        chk("idle_x_out_valid", {24'h0, out_valid}, 32'h00);
        chk("idle_x_slot0", slot(0), 32'h1);

        // Asynchronous reset clears a full slot between edges
        controlador = 3'd2; entrada = 32'hAAAA0002; in_valid = 1'b1;
        step();
        chk("w2_out_valid", {24'h0, out_valid}, 32'h04);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {24'h0, out_valid}, 32'h00);
        chk("arst_slot2", slot(2), 32'h0);
        step();
        chk("arst_held_valid", {24'h0, out_valid}, 32'h00);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();
        chk("post_rst_valid", {24'h0, out_valid}, 32'h00);

`ifdef DEMUX_BCAST_EN
        bcast = 1'b1; entrada = 32'hA5A5A5A5; in_valid = 1'b1; controlador = 3'd1; #1;
        chk("bc_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0; bcast = 1'b0;
        chk("bc_out_valid", {24'h0, out_valid}, 32'hFF);
        for (int k = 0; k < 8; k++) chk($sformatf("bc_slot%0d", k), slot(k), 32'hA5A5A5A5);
        out_ready = 8'hEF;
        step();
        out_ready = 8'h00;
        chk("bc_only4", {24'h0, out_valid}, 32'h10);
        bcast = 1'b1; in_valid = 1'b1; entrada = 32'h5A5A5A5A; #1;
        chk("bc_blocked_ready", {31'h0, in_ready}, 32'h0);
        step();
        in_valid = 1'b0; bcast = 1'b0;
        chk("bc_blocked_valid", {24'h0, out_valid}, 32'h10);
        chk("bc_blocked_slot4", slot(4), 32'hA5A5A5A5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
